// File: rtl/vdp_super_arb_pkg.sv
// Shared types and helpers for the super-res VRAM arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vdp_super_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        CPU  = 2'd2,
        CMD  = 2'd3
    } owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // One-hot byte enable for the byte lane selected by addr[1:0].
    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Extract the byte in the given lane of a 32-bit word (lane 0 = bits 7:0).
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return 8'(word >> {lane, 3'b000});
    endfunction

endpackage

// File: rtl/vdp_arb_starve_counter.sv
// Per-requester wait counter; flags a requester that has waited LIMIT cycles.
// Latency: starved reflects the registered count (one cycle behind req/granted).
// Backpressure: none; counts while req is held and not being served.
module vdp_arb_starve_counter #(
    parameter int LIMIT = 48
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic granted,
    output logic starved
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] count;

    // Count waiting cycles, saturating at LIMIT; clear when idle or served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!req || granted) begin
            count <= '0;
        end else if (count != LIM) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count == LIM);

endmodule

// File: rtl/vdp_super_vram_arbiter.sv
// Arbitrates the 32-bit VRAM port between display fetch, CPU bytes and command-engine bytes.
// Latency: request sampled in IDLE -> mem_req next cycle; mem_ack -> ack/valid next cycle.
// Backpressure: mem_* held constant until mem_ack; requesters hold req until their pulse.
module vdp_super_vram_arbiter
    import vdp_super_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        drawing,
    input  logic        disp_req,
    input  logic [17:0] disp_addr,
    output logic        disp_valid,
    output logic [31:0] disp_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [19:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ack,
    output logic [7:0]  cmd_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    arb_state_t state, state_nxt;
    owner_t     owner, win, grant, rr_pick;
    logic       rr_ptr;       // 0: CPU preferred on a tie, 1: command engine preferred
    logic [1:0] lane;         // byte lane of the transfer in flight
    logic       cpu_m, cmd_m, disp_m;
    logic       cpu_starved, cmd_starved;

    logic [19:0] sel_addr;
    logic        sel_we;
    logic [7:0]  sel_wdata;
    logic        nxt_we;
    logic [17:0] nxt_addr;
    logic [3:0]  nxt_be;
    logic [31:0] nxt_wdata;

    // A requester whose pulse is out this cycle is already served; hide its req.
    assign cpu_m  = cpu_req  & ~cpu_ack;
    assign cmd_m  = cmd_req  & ~cmd_ack;
    assign disp_m = disp_req & ~disp_valid;

    vdp_arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_cpu_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (cpu_req),
        .granted ((grant == CPU) || (owner == CPU)),
        .starved (cpu_starved)
    );

    vdp_arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_cmd_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (cmd_req),
        .granted ((grant == CMD) || (owner == CMD)),
        .starved (cmd_starved)
    );

    // Pick the winner: starved byte requester, then display (drawing window), else round-robin.
    always_comb begin
        rr_pick = NONE;
        win     = NONE;
        if (cpu_m && cmd_m) rr_pick = rr_ptr ? CMD : CPU;
        else if (cpu_m)     rr_pick = CPU;
        else if (cmd_m)     rr_pick = CMD;

        if (drawing) begin
            if (cpu_starved && cpu_m)      win = CPU;
            else if (cmd_starved && cmd_m) win = CMD;
            else if (disp_m)               win = DISP;
            else                           win = rr_pick;
        end else begin
            if (rr_pick != NONE)           win = rr_pick;
            else if (disp_m)               win = DISP;
        end
    end

    // Next-state logic: grant only from IDLE, return to IDLE on controller ack.
    always_comb begin
        state_nxt = state;
        grant     = NONE;
        case (state)
            IDLE: begin
                if (win != NONE) begin
                    grant     = win;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Build the memory request for the granted requester.
    always_comb begin
        sel_addr  = cpu_addr;
        sel_we    = cpu_we;
        sel_wdata = cpu_wdata;
        if (grant == CMD) begin
            sel_addr  = cmd_addr;
            sel_we    = cmd_we;
            sel_wdata = cmd_wdata;
        end
        if (grant == DISP) begin
            nxt_we    = 1'b0;
            nxt_addr  = disp_addr;
            nxt_be    = 4'b1111;
            nxt_wdata = '0;
        end else begin
            nxt_we    = sel_we;
            nxt_addr  = sel_addr[19:2];
            nxt_be    = sel_we ? byte_be(sel_addr[1:0]) : 4'b1111;
            nxt_wdata = {4{sel_wdata}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Issue registers, owner/round-robin bookkeeping and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= NONE;
            rr_ptr     <= 1'b0;
            lane       <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            cmd_ack    <= 1'b0;
            cmd_rdata  <= '0;
        end else begin
            disp_valid <= 1'b0;
            cpu_ack    <= 1'b0;
            cmd_ack    <= 1'b0;
            if (grant != NONE) begin
                owner     <= grant;
                mem_req   <= 1'b1;
                mem_we    <= nxt_we;
                mem_addr  <= nxt_addr;
                mem_be    <= nxt_be;
                mem_wdata <= nxt_wdata;
                lane      <= sel_addr[1:0];
                if (grant == CPU)      rr_ptr <= 1'b1;
                else if (grant == CMD) rr_ptr <= 1'b0;
            end else if ((state == BUSY) && mem_ack) begin
                mem_req <= 1'b0;
                owner   <= NONE;
                case (owner)
                    DISP: begin
                        disp_valid <= 1'b1;
                        disp_data  <= mem_rdata;
                    end
                    CPU: begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= lane_byte(mem_rdata, lane);
                    end
                    CMD: begin
                        cmd_ack   <= 1'b1;
                        cmd_rdata <= lane_byte(mem_rdata, lane);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
